// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 console transmitter: DATA register push, STATUS register read/clear.
// Define UART_FIFO_EN for a FIFO_DEPTH-entry queue; otherwise a single-byte holding register is used.
module uart_tx_mmio #(
    parameter logic [31:0] BASE_ADDR  = 32'h10000000,
    parameter int unsigned CLK_DIV    = 868,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bus_wren,
    input  logic [3:0]  bus_wmask,
    input  logic [31:0] bus_wdata,
    input  logic [31:0] bus_addr,
    output logic [31:0] bus_rdata,
    output logic        tx,
    output logic        tx_busy
);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    localparam logic [15:0] DIV_M1 = 16'(CLK_DIV - 1);

    logic       hit_data;
    logic       hit_stat;
    logic       push_req;
    logic       push_ok;
    logic       clr_req;
    logic       ovf_set;
    logic       pop;
    logic       full;
    logic       empty;
    logic       ovf;
    logic [7:0] head;
    logic       unused_bits;

    state_t      state, state_n;
    logic [15:0] timer, timer_n;
    logic [2:0]  bitcnt, bitcnt_n;
    logic [7:0]  shreg, shreg_n;
    logic        tx_q, tx_n;

    assign hit_data = (bus_addr[31:3] == BASE_ADDR[31:3]) && !bus_addr[2];
    assign hit_stat = (bus_addr[31:3] == BASE_ADDR[31:3]) &&  bus_addr[2];
    assign push_req = bus_wren && bus_wmask[0] && hit_data;
    assign clr_req  = bus_wren && bus_wmask[0] && hit_stat && bus_wdata[3];

    // A pop in the same cycle frees the slot, so a push into a full queue still lands.
    assign push_ok  = push_req && (!full || pop);
    assign ovf_set  = push_req && full && !pop;

    assign unused_bits = ^{bus_wdata[31:8], bus_wmask[3:1], bus_addr[1:0]};

`ifdef UART_FIFO_EN
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [AW:0] rd_ptr;
    logic [AW:0] wr_ptr;
    logic [7:0]  mem [FIFO_DEPTH];

    assign empty = (rd_ptr == wr_ptr);
    assign full  = (rd_ptr[AW] != wr_ptr[AW]) && (rd_ptr[AW-1:0] == wr_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= bus_wdata[7:0];
        end
    end
`else
    localparam int unsigned unused_depth = FIFO_DEPTH;

    logic [7:0] hold;
    logic       hold_vld;

    assign empty = !hold_vld;
    assign full  = hold_vld;
    assign head  = hold;

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_vld <= 1'b0;
            hold     <= '0;
        end else if (push_ok) begin
            hold_vld <= 1'b1;
            hold     <= bus_wdata[7:0];
        end else if (pop) begin
            hold_vld <= 1'b0;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (ovf_set) begin
            ovf <= 1'b1;
        end else if (clr_req) begin
            ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            timer  <= '0;
            bitcnt <= '0;
            shreg  <= '0;
            tx_q   <= 1'b1;
        end else begin
            state  <= state_n;
            timer  <= timer_n;
            bitcnt <= bitcnt_n;
            shreg  <= shreg_n;
            tx_q   <= tx_n;
        end
    end

    // tx is computed one cycle ahead so the registered line lines up with the state.
    always_comb begin
        state_n  = state;
        timer_n  = timer;
        bitcnt_n = bitcnt;
        shreg_n  = shreg;
        tx_n     = tx_q;
        pop      = 1'b0;
        unique case (state)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_n = START;
                    timer_n = DIV_M1;
                    shreg_n = head;
                    tx_n    = 1'b0;
                end
            end
            START: begin
                if (timer == 16'd0) begin
                    state_n  = DATA;
                    timer_n  = DIV_M1;
                    bitcnt_n = 3'd0;
                    tx_n     = shreg[0];
                end else begin
                    timer_n = timer - 16'd1;
                end
            end
            DATA: begin
                if (timer == 16'd0) begin
                    timer_n  = DIV_M1;
                    bitcnt_n = bitcnt + 3'd1;
                    if (bitcnt == 3'd7) begin
                        state_n = STOP;
                        tx_n    = 1'b1;
                    end else begin
                        shreg_n = {1'b0, shreg[7:1]};
                        tx_n    = shreg[1];
                    end
                end else begin
                    timer_n = timer - 16'd1;
                end
            end
            STOP: begin
                if (timer == 16'd0) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        state_n = START;
                        timer_n = DIV_M1;
                        shreg_n = head;
                        tx_n    = 1'b0;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    timer_n = timer - 16'd1;
                end
            end
            default: begin
                state_n = IDLE;
                tx_n    = 1'b1;
            end
        endcase
    end

    assign tx      = tx_q;
    assign tx_busy = !empty || (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            bus_rdata <= '0;
        end else begin
            bus_rdata <= hit_stat ? {28'd0, ovf, empty, full, tx_busy} : '0;
        end
    end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Self-checking bench for uart_tx_mmio: queue/frame model, serial receiver and directed scenarios.
// Define UART_FIFO_EN to match the RTL build; the model depth follows it.
module tb_uart_tx_mmio;

    localparam logic [31:0] BASE  = 32'h10000000;
    localparam logic [31:0] STAT  = 32'h10000004;
    localparam int          DIV   = 4;
    localparam int          FRAME = 10 * DIV;
`ifdef UART_FIFO_EN
    localparam int DEPTH  = 8;
    localparam int BURSTN = 9;
`else
    localparam int DEPTH  = 1;
    localparam int BURSTN = 2;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        bus_wren = 1'b0;
    logic [3:0]  bus_wmask = '0;
    logic [31:0] bus_wdata = '0;
    logic [31:0] bus_addr = '0;
    logic [31:0] bus_rdata;
    logic        tx;
    logic        tx_busy;

    int total = 0;
    int bad = 0;
    int cycle = 0;
    int rst_epoch = 0;

    always #5 clk = ~clk;

    uart_tx_mmio #(
        .BASE_ADDR (BASE),
        .CLK_DIV   (DIV),
        .FIFO_DEPTH(8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus_wren (bus_wren),
        .bus_wmask(bus_wmask),
        .bus_wdata(bus_wdata),
        .bus_addr (bus_addr),
        .bus_rdata(bus_rdata),
        .tx       (tx),
        .tx_busy  (tx_busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %h want %h", name, cycle, act, exp);
        end
    endtask

    // Model: byte queue plus a frame position counter; the line level is derived from the frame rules.
    logic [7:0]  mq[$];
    logic        m_ovf = 1'b0;
    logic        m_act = 1'b0;
    int          m_pos = 0;
    logic [7:0]  m_cur = '0;
    logic [31:0] m_rdata = '0;
    logic        m_tx = 1'b1;
    logic        m_busy = 1'b0;
    logic        m_on = 1'b0;

    function automatic logic frame_bit(input logic act, input logic [7:0] cur, input int pos);
        int idx;
        if (!act) return 1'b1;
        idx = pos / DIV;
        if (idx == 0) return 1'b0;
        if (idx <= 8) return cur[idx-1];
        return 1'b1;
    endfunction

    always @(posedge clk) begin : model
        logic hs, hd, full_pre, pop, fend;
        logic [31:0] st;
        cycle++;
        if (rst) begin
            rst_epoch++;
            mq.delete();
            m_ovf   = 1'b0;
            m_act   = 1'b0;
            m_pos   = 0;
            m_rdata = '0;
            m_on    = 1'b1;
        end else begin
            hs = ((bus_addr >> 3) == (BASE >> 3)) && bus_addr[2];
            hd = ((bus_addr >> 3) == (BASE >> 3)) && !bus_addr[2];
            st = {28'd0, m_ovf, (mq.size() == 0), (mq.size() == DEPTH), ((mq.size() != 0) || m_act)};
            m_rdata  = hs ? st : 32'd0;
            full_pre = (mq.size() == DEPTH);
            fend     = m_act && (m_pos == FRAME - 1);
            pop      = (mq.size() != 0) && (!m_act || fend);
            if (pop) begin
                m_cur = mq.pop_front();
                m_act = 1'b1;
                m_pos = 0;
            end else if (fend) begin
                m_act = 1'b0;
            end else if (m_act) begin
                m_pos++;
            end
            if (bus_wren && bus_wmask[0] && hd) begin
                if (full_pre && !pop) m_ovf = 1'b1;
                else mq.push_back(bus_wdata[7:0]);
            end
            if (bus_wren && bus_wmask[0] && hs && bus_wdata[3]) m_ovf = 1'b0;
        end
        m_busy = (mq.size() != 0) || m_act;
        m_tx   = frame_bit(m_act, m_cur, m_pos);
        #1;
        if (m_on) begin
            chk("tx", tx, m_tx);
            chk("tx_busy", tx_busy, m_busy);
            chk("bus_rdata", bus_rdata, m_rdata);
        end
    end

    // Serial receiver: samples mid-bit, drops any frame interrupted by reset.
    logic [7:0] rxq[$];
    initial begin : rx
        forever begin
            @(posedge clk); #2;
            if (!rst && tx === 1'b0) begin : frame
                logic [7:0] b;
                int ep;
                ep = rst_epoch;
                repeat (DIV / 2) @(posedge clk);
                #2;
                for (int k = 0; k < 8; k++) begin
                    repeat (DIV) @(posedge clk);
                    #2;
                    b[k] = tx;
                end
                repeat (DIV) @(posedge clk);
                #2;
                if (ep == rst_epoch && tx === 1'b1) rxq.push_back(b);
            end
        end
    end

    task automatic idle_bus();
        bus_wren  = 1'b0;
        bus_wmask = '0;
        bus_wdata = '0;
        bus_addr  = '0;
    endtask

    task automatic store(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
        @(negedge clk);
        bus_wren = 1'b1; bus_addr = a; bus_wmask = m; bus_wdata = d;
        @(negedge clk);
        idle_bus();
    endtask

    task automatic read_addr(input logic [31:0] a, output logic [31:0] v);
        @(negedge clk);
        idle_bus();
        bus_addr = a;
        @(posedge clk); #1;
        v = bus_rdata;
        @(negedge clk);
        idle_bus();
    endtask

    task automatic wait_idle(input int limit, output int at);
        int n;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (tx_busy !== 1'b0 && n < limit);
        at = cycle;
        if (tx_busy !== 1'b0) chk("idle_timeout", tx_busy, 0);
    endtask

    task automatic chk_rx(input string name, input int n, input logic [7:0] first, input logic [7:0] step_b);
        chk({name, "_count"}, rxq.size(), n);
        for (int i = 0; i < n; i++) begin
            chk(name, (i < rxq.size()) ? {56'd0, rxq[i]} : 64'hFFFF, 8'(first + 8'(i) * step_b));
        end
        rxq.delete();
    endtask

    initial begin : stim
        logic [31:0] v;
        logic [39:0] got, want;
        int          pat [10];
        logic        busy_all;
        int          c0, c1, zeros;

        // Reset and status after reset
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("reset_tx", tx, 1);
        chk("reset_busy", tx_busy, 0);
        chk("reset_rdata", bus_rdata, 0);
        read_addr(STAT, v);
        chk("reset_status", v, 32'h4);

        // Single byte 0x41: 10 bits of 4 cycles each
        pat = '{0, 1, 0, 0, 0, 0, 0, 1, 0, 1};
        for (int i = 0; i < 40; i++) want[i] = pat[i / 4][0];
        busy_all = 1'b1;
        store(BASE, 4'b0001, 32'h41);
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            got[i] = tx;
            busy_all = busy_all & tx_busy;
        end
        chk("frame_0x41", got, want);
        chk("busy_in_frame", busy_all, 1);
        @(posedge clk); #1;
        chk("busy_after_stop", tx_busy, 0);
        chk_rx("rx_0x41", 1, 8'h41, 8'h00);

        // Non-pushing stores
        store(BASE, 4'b0010, 32'h55);
        store(BASE + 32'd8, 4'b0001, 32'h55);
        repeat (10) @(posedge clk);
        #1;
        chk("nopush_tx", tx, 1);
        read_addr(STAT, v);
        chk("nopush_status", v, 32'h4);
        read_addr(BASE, v);
        chk("data_read_zero", v, 0);
        read_addr(BASE + 32'd8, v);
        chk("miss_read_zero", v, 0);

        // Burst of 10 back-to-back stores, overflow then clear
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 0) c0 = cycle + 1;
            bus_wren = 1'b1; bus_addr = BASE; bus_wmask = 4'b0001; bus_wdata = 32'h30 + i;
        end
        @(negedge clk);
        idle_bus();
        bus_addr = STAT;
        @(posedge clk); #1;
        chk("burst_status", bus_rdata, 32'hB);
        @(negedge clk);
        bus_wren = 1'b1; bus_wmask = 4'b0001; bus_wdata = 32'h8;
        @(negedge clk);
        bus_wren = 1'b0; bus_wdata = '0;
        @(posedge clk); #1;
        chk("ovf_cleared", bus_rdata, 32'h3);
        @(negedge clk);
        idle_bus();
        wait_idle(2000, c1);
        chk("burst_busy_span", c1 - c0, FRAME * BURSTN + 1);
        chk_rx("rx_burst", BURSTN, 8'h30, 8'h01);
        read_addr(STAT, v);
        chk("burst_end_status", v, 32'h4);

`ifndef UART_FIFO_EN
        // Holding register: byte1 shifts, byte2 held, byte3 dropped
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus_wren = 1'b1; bus_addr = BASE; bus_wmask = 4'b0001;
            bus_wdata = (i == 0) ? 32'h5A : (i == 1) ? 32'hC3 : 32'h77;
        end
        @(negedge clk);
        idle_bus();
        wait_idle(500, c1);
        chk("hold_rx_count", rxq.size(), 2);
        chk("hold_rx0", (rxq.size() > 0) ? rxq[0] : 8'h00, 8'h5A);
        chk("hold_rx1", (rxq.size() > 1) ? rxq[1] : 8'h00, 8'hC3);
        rxq.delete();
        read_addr(STAT, v);
        chk("hold_ovf_status", v, 32'hC);
`endif

        // Reset in the middle of a frame with bytes queued
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus_wren = 1'b1; bus_addr = BASE; bus_wmask = 4'b0001; bus_wdata = 32'hA0 + i;
        end
        @(negedge clk);
        idle_bus();
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_tx", tx, 1);
        chk("midrst_busy", tx_busy, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        zeros = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (tx !== 1'b1) zeros++;
        end
        chk("post_rst_line_low", zeros, 0);
        chk("post_rst_busy", tx_busy, 0);
        chk("post_rst_rx", rxq.size(), 0);
        read_addr(STAT, v);
        chk("post_rst_status", v, 32'h4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
